// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared sizing constants and FSM state type for the square-root unit
// Contents: SQRT_DATA_W radicand width, SQRT_RES_W root width,
//           SQRT_CNT_W iteration-counter width, sqrt_state_t FSM states.
package sqrt_pkg;
  localparam int SQRT_DATA_W = 16;
  localparam int SQRT_RES_W = SQRT_DATA_W / 2;
  localparam int SQRT_CNT_W = $clog2(SQRT_RES_W + 1);
  typedef enum logic {IDLE, CALC} sqrt_state_t;
endpackage

// File: rtl/sqrt_iter_unit_if.sv
// sqrt_iter_unit_if: request/result bundle between the controller FSM and the square-root unit
// Signals: start_sqrt, radicand (controller -> unit);
//          busy, sqrt_done, root, remainder (unit -> controller).
// Modports: master = controller side, slave = square-root unit.
interface sqrt_iter_unit_if #(parameter int DATA_W = 16);
  localparam int RES_W = DATA_W / 2;
  logic start_sqrt;
  logic [DATA_W-1:0] radicand;
  logic busy;
  logic sqrt_done;
  logic [RES_W-1:0] root;
  logic [RES_W:0] remainder;
  modport master (output start_sqrt, radicand, input busy, sqrt_done, root, remainder);
  modport slave (input start_sqrt, radicand, output busy, sqrt_done, root, remainder);
endinterface

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring square-root iteration
// Ports: rem/acc = working remainder and partial root, bits = next two radicand bits,
//        rem_nx/acc_nx = values after this iteration.
module sqrt_step #(parameter int RES_W = 8) (
  input  logic [RES_W+1:0] rem,
  input  logic [RES_W-1:0] acc,
  input  logic [1:0]       bits,
  output logic [RES_W+1:0] rem_nx,
  output logic [RES_W-1:0] acc_nx
);
  logic [RES_W+1:0] rem_sh, trial;
  logic ge;
  assign rem_sh = (rem << 2) | {{RES_W{1'b0}}, bits};
  assign trial = {acc, 2'b01};
  assign ge = rem_sh >= trial;
  assign rem_nx = ge ? rem_sh - trial : rem_sh;
  assign acc_nx = (acc << 1) | {{(RES_W-1){1'b0}}, ge};
endmodule

// File: rtl/sqrt_iter_unit.sv
// sqrt_iter_unit: iterative integer square root, one root bit per clock
// Ports: clk, reset_n (async, active-low), bus (sqrt_iter_unit_if.slave):
//        start_sqrt/radicand in, busy/sqrt_done/root/remainder out.
// Optional macro SQRT_ROUND_EN: root rounds to nearest (saturating); remainder stays floor-based.
module sqrt_iter_unit import sqrt_pkg::*; #(
  parameter int DATA_W = SQRT_DATA_W
) (
  input logic clk,
  input logic reset_n,
  sqrt_iter_unit_if.slave bus
);
  localparam int RES_W = DATA_W / 2;
  localparam int CNT_W = $clog2(RES_W + 1);
  sqrt_state_t state, state_nx;
  logic [DATA_W-1:0] x;
  logic [RES_W+1:0] rem, rem_nx;
  logic [RES_W-1:0] acc, acc_nx, root_fin, root_q;
  logic [RES_W:0] remainder_q;
  logic [CNT_W-1:0] cnt;
  logic done_q, last;
  sqrt_step #(.RES_W(RES_W)) u_step (
    .rem(rem),
    .acc(acc),
    .bits(x[DATA_W-1 -: 2]),
    .rem_nx(rem_nx),
    .acc_nx(acc_nx)
  );
  assign last = cnt == CNT_W'(1);
`ifdef SQRT_ROUND_EN
  // round up when the floor remainder exceeds the floor root, without wrapping past all-ones
  assign root_fin = (rem_nx > {2'b00, acc_nx} && acc_nx != '1) ? acc_nx + RES_W'(1) : acc_nx;
`else
  assign root_fin = acc_nx;
`endif
  always_comb state_nx = state == IDLE ? (bus.start_sqrt ? CALC : IDLE) : (last ? IDLE : CALC);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      rem <= '0;
      acc <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      root_q <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && bus.start_sqrt) begin
        x <= bus.radicand;
        rem <= '0;
        acc <= '0;
        cnt <= CNT_W'(RES_W);
      end else if (state == CALC) begin
        x <= x << 2;
        rem <= rem_nx;
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          done_q <= 1'b1;
          root_q <= root_fin;
          remainder_q <= rem_nx[RES_W:0];
        end
      end
    end
  end
  assign bus.busy = state == CALC;
  assign bus.sqrt_done = done_q;
  assign bus.root = root_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb_sqrt_iter_unit: directed scoreboard bench for sqrt_iter_unit
module tb_sqrt_iter_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [16:0] q[$];
  sqrt_iter_unit_if bus_if ();
  sqrt_iter_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int x);
    int r = 0;
    int rt;
    while ((r + 1) * (r + 1) <= x) r++;
    rt = r;
`ifdef SQRT_ROUND_EN
    if (x - r * r > r) rt = (r < 255) ? r + 1 : 255;
`endif
    return {8'(rt), 9'(x - r * r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] x, input bit track);
    bus_if.start_sqrt = 1'b1;
    bus_if.radicand = x;
    if (track) q.push_back(model(int'(x)));
    @(posedge clk);
    #1;
    bus_if.start_sqrt = 1'b0;
    bus_if.radicand = 16'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input bit hold_chk,
                           input logic [7:0] hold, input bit pulse);
    int lat = 0;
    int bcnt = 0;
    int holdbad = 0;
    logic [16:0] e;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus_if.sqrt_done) begin
        lat = i;
        break;
      end
      if (bus_if.busy) bcnt++;
      if (hold_chk && bus_if.root !== hold) holdbad++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bcnt, exp_lat - 1);
    chk({tag, "_busy_at_done"}, bus_if.busy, 0);
    if (hold_chk) chk({tag, "_root_held"}, holdbad, 0);
    chk({tag, "_sb_nonempty"}, q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_root"}, bus_if.root, e[16:9]);
      chk({tag, "_remainder"}, bus_if.remainder, e[8:0]);
    end
    if (pulse) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, bus_if.sqrt_done, 0);
    end
  endtask

  initial begin
    int dcnt;
    logic [15:0] vals[5] = '{16'd144, 16'd200, 16'hFFFF, 16'd210, 16'd211};
    bus_if.start_sqrt = 1'b0;
    bus_if.radicand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.sqrt_done, 0);
    chk("rst_root", bus_if.root, 0);
    chk("rst_remainder", bus_if.remainder, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(16'd0, 1);
    wait_done("zero", 9, 0, 8'd0, 1);
    foreach (vals[i]) begin
      start_op(vals[i], 1);
      wait_done($sformatf("dir%0d", vals[i]), 9, 0, 8'd0, 1);
    end
    repeat (4) begin
      start_op(16'($urandom), 1);
      wait_done("rand", 9, 0, 8'd0, 1);
    end
    start_op(16'd144, 1);
    repeat (2) @(posedge clk);
    #1;
    start_op(16'd9, 0);
    wait_done("ovl", 6, 0, 8'd0, 0);
    start_op(16'd9, 1);
    wait_done("b2b", 9, 1, 8'd12, 1);
    start_op(16'd40000, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus_if.busy, 0);
    chk("mid_rst_done", bus_if.sqrt_done, 0);
    chk("mid_rst_root", bus_if.root, 0);
    chk("mid_rst_remainder", bus_if.remainder, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.sqrt_done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    start_op(16'd40000, 1);
    wait_done("after_rst", 9, 0, 8'd0, 1);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
